// File: rtl/psum_acc_buffer_if.sv
// Bundle of the write/accumulate, read and clear signals of psum_acc_buffer.
// Valid/ready rule: a write is taken on a rising edge where in_valid and
// in_ready are both high; in_valid/in_addr/in_acc/in_data are held by the
// master until that edge. rd_req and clear are single-cycle requests.
interface psum_acc_buffer_if #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ADDR_W  = 11
);
  logic                     mode;
  logic                     in_valid;
  logic                     in_ready;
  logic [ADDR_W-1:0]        in_addr;
  logic                     in_acc;
  logic [PSUM_BW*COL-1:0]   in_data;
  logic                     rd_req;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     out_valid;
  logic [PSUM_BW*COL-1:0]   out_data;
  logic                     clear;
  logic                     clear_done;

  modport master (
    output mode, in_valid, in_addr, in_acc, in_data, rd_req, rd_addr, clear,
    input  in_ready, out_valid, out_data, clear_done
  );

  modport slave (
    input  mode, in_valid, in_addr, in_acc, in_data, rd_req, rd_addr, clear,
    output in_ready, out_valid, out_data, clear_done
  );
endinterface

// File: rtl/psum_acc_buffer.sv
// Partial-sum accumulation buffer: DEPTH entries of COL signed lanes.
// Writes run through a 2-stage read-modify-write pipeline with forwarding,
// reads return one cycle after rd_req, and clear zero-fills every entry.
// Optional macro PSUM_SAT_EN: saturating lane adds instead of wrapping.
module psum_acc_buffer #(
  parameter  int COL     = 8,
  parameter  int PSUM_BW = 16,
  parameter  int DEPTH   = 2048,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int DW      = PSUM_BW * COL
) (
  input  logic                 clk,
  input  logic                 reset,
  psum_acc_buffer_if.slave     bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_CLEAR = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DW-1:0]     mem [DEPTH];
  logic [DW-1:0]     r_mem_q;

  state_t            r_state, w_next_state;
  logic [ADDR_W-1:0] r_clr_addr;

  // Stage B holds the request accepted in the previous cycle.
  logic              r_b_valid, r_b_acc;
  logic [ADDR_W-1:0] r_b_addr;
  logic [DW-1:0]     r_b_data;

  // Most recently written entry.
  logic              r_lw_valid;
  logic [ADDR_W-1:0] r_lw_addr;
  logic [DW-1:0]     r_lw_data;

  // Forwarding decision made alongside the RAM read, applied a cycle later.
  logic              r_fwd;
  logic [DW-1:0]     r_fwd_data;

  logic              r_out_valid;
  logic [DW-1:0]     r_out_hold;

  logic              w_rd_fire, w_wr_fire, w_acc, w_clr_we, w_fwd;
  logic [ADDR_W-1:0] w_port_addr, w_mem_waddr;
  logic [DW-1:0]     w_port_data, w_b_result, w_fwd_data, w_mem_wdata;
  logic              w_mem_we;
  logic signed [PSUM_BW-1:0] w_lane_a, w_lane_b, w_lane_res;
`ifdef PSUM_SAT_EN
  logic [PSUM_BW:0]  w_lane_sum;
`endif

  // The single RAM read port serves either a read or the stage-A lookup;
  // the two never happen in the same cycle because reads block writes.
  assign w_rd_fire   = bus.rd_req && (r_state == S_IDLE) && !bus.clear;
  assign w_wr_fire   = bus.in_valid && bus.in_ready;
  assign w_acc       = bus.in_acc && !bus.mode;
  assign w_port_addr = w_rd_fire ? bus.rd_addr : bus.in_addr;
  assign w_port_data = r_fwd ? r_fwd_data : r_mem_q;

  // Per-lane add/overwrite for the stage-B entry, no carries between lanes.
  always_comb begin
    w_b_result = '0;
    w_lane_a   = '0;
    w_lane_b   = '0;
    w_lane_res = '0;
`ifdef PSUM_SAT_EN
    w_lane_sum = '0;
`endif
    for (int i = 0; i < COL; i++) begin
      w_lane_a = w_port_data[i*PSUM_BW +: PSUM_BW];
      w_lane_b = r_b_data[i*PSUM_BW +: PSUM_BW];
`ifdef PSUM_SAT_EN
      w_lane_sum = {w_lane_a[PSUM_BW-1], w_lane_a} + {w_lane_b[PSUM_BW-1], w_lane_b};
      if (w_lane_sum[PSUM_BW] != w_lane_sum[PSUM_BW-1])
        w_lane_res = w_lane_sum[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}}
                                         : {1'b0, {(PSUM_BW-1){1'b1}}};
      else
        w_lane_res = w_lane_sum[PSUM_BW-1:0];
`else
      w_lane_res = w_lane_a + w_lane_b;
`endif
      w_b_result[i*PSUM_BW +: PSUM_BW] = r_b_acc ? w_lane_res : w_lane_b;
    end
  end

  // Pick a newer value than the RAM holds: stage B first, then last write.
  always_comb begin
    w_fwd      = 1'b0;
    w_fwd_data = '0;
    if (r_b_valid && (r_b_addr == w_port_addr)) begin
      w_fwd      = 1'b1;
      w_fwd_data = w_b_result;
    end else if (r_lw_valid && (r_lw_addr == w_port_addr)) begin
      w_fwd      = 1'b1;
      w_fwd_data = r_lw_data;
    end
  end

  // RAM write source: stage-B writeback or zero-fill (never both).
  always_comb begin
    w_mem_we    = r_b_valid || w_clr_we;
    w_mem_waddr = r_b_valid ? r_b_addr : r_clr_addr;
    w_mem_wdata = r_b_valid ? w_b_result : '0;
  end

  // Storage array: synchronous write and read, never reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) mem[w_mem_waddr] <= w_mem_wdata;
    r_mem_q <= mem[w_port_addr];
  end

  // Pipeline, forwarding and read-output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_b_valid   <= 1'b0;
      r_b_acc     <= 1'b0;
      r_b_addr    <= '0;
      r_b_data    <= '0;
      r_lw_valid  <= 1'b0;
      r_lw_addr   <= '0;
      r_lw_data   <= '0;
      r_fwd       <= 1'b0;
      r_fwd_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_hold  <= '0;
    end else begin
      r_b_valid   <= w_wr_fire;
      r_b_acc     <= w_acc;
      r_b_addr    <= bus.in_addr;
      r_b_data    <= bus.in_data;
      r_fwd       <= w_fwd;
      r_fwd_data  <= w_fwd_data;
      r_out_valid <= w_rd_fire;
      if (r_out_valid) r_out_hold <= w_port_data;
      if (r_b_valid) begin
        r_lw_valid <= 1'b1;
        r_lw_addr  <= r_b_addr;
        r_lw_data  <= w_b_result;
      end else if (w_clr_we) begin
        r_lw_valid <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state: a clear waits in DRAIN until stage B is empty.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.clear) w_next_state = S_DRAIN;
      S_DRAIN: if (!r_b_valid) w_next_state = S_CLEAR;
      S_CLEAR: if (r_clr_addr == LAST_ADDR) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.in_ready   = (r_state == S_IDLE) && !bus.clear && !bus.rd_req;
    bus.clear_done = (r_state == S_CLEAR) && (r_clr_addr == LAST_ADDR);
    w_clr_we       = (r_state == S_CLEAR);
  end

  // Zero-fill address counter, saturating at the last entry.
  always_ff @(posedge clk) begin
    if (reset || (r_state != S_CLEAR)) r_clr_addr <= '0;
    else if (r_clr_addr != LAST_ADDR)  r_clr_addr <= r_clr_addr + 1'b1;
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_valid ? w_port_data : r_out_hold;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_psum_acc_buffer.sv
// Directed bench for psum_acc_buffer: vector table plus hand sequences for
// back-to-back accumulation, read/write collision, overflow and clear/reset.
module tb_psum_acc_buffer;
  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int DEPTH   = 2048;
  localparam int ADDR_W  = 11;
  localparam int DW      = COL * PSUM_BW;

  typedef struct {
    logic              mode;
    logic              acc;
    logic [ADDR_W-1:0] addr;
    int                val;
    int                exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  psum_acc_buffer_if #(.COL(COL), .PSUM_BW(PSUM_BW), .ADDR_W(ADDR_W)) bus ();

  psum_acc_buffer #(.COL(COL), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input int v);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) r[i*PSUM_BW +: PSUM_BW] = v[PSUM_BW-1:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one write and hold it until accepted (bounded).
  task automatic wr(input logic m, input logic a, input logic [ADDR_W-1:0] ad, input logic [DW-1:0] d);
    int guard;
    bus.mode     = m;
    bus.in_acc   = a;
    bus.in_addr  = ad;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    #1;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check_bit("wr_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // One-cycle read; result expected on the following cycle.
  task automatic rd(input logic [ADDR_W-1:0] ad, input logic [DW-1:0] exp, input string name);
    logic [DW-1:0] e;
    bus.rd_req  = 1'b1;
    bus.rd_addr = ad;
    exp_q.push_back(exp);
    tick();
    bus.rd_req = 1'b0;
    e = exp_q.pop_front();
    check_bit({name, "_valid"}, bus.out_valid, 1'b1);
    check_vec({name, "_data"}, bus.out_data, e);
  endtask

  initial begin
    vec_t          vecs[8];
    logic [DW-1:0] d0, d1, e_ovf;
    int            done_cnt;

    vecs[0] = '{1'b0, 1'b0, 11'd5,    3,     3};
    vecs[1] = '{1'b0, 1'b1, 11'd5,    4,     7};
    vecs[2] = '{1'b0, 1'b1, 11'd5,    -10,   -3};
    vecs[3] = '{1'b1, 1'b1, 11'd5,    2,     2};
    vecs[4] = '{1'b0, 1'b0, 11'd0,    100,   100};
    vecs[5] = '{1'b0, 1'b1, 11'd0,    -1,    99};
    vecs[6] = '{1'b0, 1'b0, 11'd2047, 1234,  1234};
    vecs[7] = '{1'b0, 1'b1, 11'd2047, -1234, 0};

    // reset
    reset        = 1'b1;
    bus.mode     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_acc   = 1'b0;
    bus.in_data  = '0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.clear    = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_vec("rst_out_data", bus.out_data, '0);
    check_bit("rst_clear_done", bus.clear_done, 1'b0);
    check_bit("rst_in_ready", bus.in_ready, 1'b1);

    // table: write then immediate read (exercises forwarding)
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].mode, vecs[i].acc, vecs[i].addr, rep(vecs[i].val));
      rd(vecs[i].addr, rep(vecs[i].exp), $sformatf("vec%0d", i));
    end

    // back-to-back accumulate into one entry
    wr(1'b0, 1'b0, 11'd5, rep(3));
    wr(1'b0, 1'b1, 11'd5, rep(4));
    wr(1'b0, 1'b1, 11'd5, rep(4));
    wr(1'b0, 1'b1, 11'd5, rep(4));
    rd(11'd5, rep(15), "b2b_acc");

    // output-stationary mode ignores in_acc
    wr(1'b1, 1'b0, 11'd9, rep(7));
    wr(1'b1, 1'b1, 11'd9, rep(2));
    rd(11'd9, rep(2), "os_store");

    // read and write in the same cycle
    wr(1'b0, 1'b0, 11'd20, rep(11));
    tick();
    bus.rd_req   = 1'b1;
    bus.rd_addr  = 11'd20;
    bus.mode     = 1'b0;
    bus.in_acc   = 1'b0;
    bus.in_addr  = 11'd20;
    bus.in_data  = rep(99);
    bus.in_valid = 1'b1;
    #1;
    check_bit("coll_ready_low", bus.in_ready, 1'b0);
    tick();
    bus.rd_req = 1'b0;
    #1;
    check_bit("coll_out_valid", bus.out_valid, 1'b1);
    check_vec("coll_old_data", bus.out_data, rep(11));
    check_bit("coll_ready_next", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    rd(11'd20, rep(99), "coll_new");

    // out_data holds while out_valid is low
    tick();
    check_bit("hold_valid_low", bus.out_valid, 1'b0);
    check_vec("hold_data", bus.out_data, rep(99));

    // lane overflow, lanes stay independent
    d0 = '0;
    d1 = '0;
    e_ovf = '0;
    d0[15:0]  = 16'h7FFF;
    d0[31:16] = 16'h8000;
    d1[15:0]  = 16'h0001;
    d1[31:16] = 16'hFFFF;
`ifdef PSUM_SAT_EN
    e_ovf[15:0]  = 16'h7FFF;
    e_ovf[31:16] = 16'h8000;
`else
    e_ovf[15:0]  = 16'h8000;
    e_ovf[31:16] = 16'h7FFF;
`endif
    for (int i = 2; i < COL; i++) begin
      d0[i*PSUM_BW +: PSUM_BW]    = 16'(100 * i);
      e_ovf[i*PSUM_BW +: PSUM_BW] = 16'(100 * i);
    end
    wr(1'b0, 1'b0, 11'd30, d0);
    wr(1'b0, 1'b1, 11'd30, d1);
    rd(11'd30, e_ovf, "ovf_fwd");
    repeat (3) tick();
    rd(11'd30, e_ovf, "ovf_mem");
    rd(11'd5, rep(15), "mem_addr5");

    // clear with writes in flight
    wr(1'b0, 1'b0, 11'd40, rep(5));
    wr(1'b0, 1'b0, 11'd41, rep(6));
    bus.clear = 1'b1;
    #1;
    check_bit("clr_ready_low", bus.in_ready, 1'b0);
    tick();
    bus.clear = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < DEPTH + 20; c++) begin
      if (bus.clear_done) done_cnt++;
      if (c == 300) check_bit("clr_busy_ready", bus.in_ready, 1'b0);
      if (c == 500) bus.clear = 1'b1;
      if (c == 600) begin
        bus.rd_req  = 1'b1;
        bus.rd_addr = 11'd41;
      end
      if (c == 601) check_bit("clr_rd_ignored", bus.out_valid, 1'b0);
      tick();
      bus.clear  = 1'b0;
      bus.rd_req = 1'b0;
    end
    check_int("clr_done_once", done_cnt, 1);
    rd(11'd41, '0, "clr_a41");
    rd(11'd40, '0, "clr_a40");
    rd(11'd0, '0, "clr_a0");
    rd(11'd2047, '0, "clr_a2047");

    // reset in the middle of a clear
    wr(1'b0, 1'b0, 11'd2047, rep(555));
    wr(1'b0, 1'b0, 11'd200, rep(77));
    wr(1'b0, 1'b0, 11'd50, rep(9));
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick();
    done_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.clear_done) done_cnt++;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_bit("abort_in_ready", bus.in_ready, 1'b1);
    check_bit("abort_done_low", bus.clear_done, 1'b0);
    check_bit("abort_out_valid", bus.out_valid, 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (bus.clear_done) done_cnt++;
      tick();
    end
    check_int("abort_no_done", done_cnt, 0);
    rd(11'd2047, rep(555), "abort_a2047");
    rd(11'd200, rep(77), "abort_a200");
    rd(11'd50, '0, "abort_a50");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/psum_acc_buffer.md
PSUM_ACC_BUFFER -- requirements
Module: psum_acc_buffer

Interface
REQ-001 SHALL have parameter COL, default 8: number of output channels (lanes).
REQ-002 SHALL have parameter PSUM_BW, default 16: signed width of one lane.
REQ-003 SHALL have parameter DEPTH, default 2048: number of entries; ADDR_W = clog2(DEPTH).
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port mode, input, 1: 0 = weight stationary (accumulate), 1 = output stationary (store).
REQ-007 SHALL have port in_valid, input, 1: write/accumulate request.
REQ-008 SHALL have port in_ready, output, 1: request accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port in_addr, input, ADDR_W: target entry.
REQ-010 SHALL have port in_acc, input, 1: 1 = add to entry, 0 = overwrite entry.
REQ-011 SHALL have port in_data, input, PSUM_BW*COL: lane i occupies bits [PSUM_BW*(i+1)-1 : PSUM_BW*i].
REQ-012 SHALL have port rd_req, input, 1: read request.
REQ-013 SHALL have port rd_addr, input, ADDR_W: read entry.
REQ-014 SHALL have port out_valid, output, 1: out_data valid this cycle.
REQ-015 SHALL have port out_data, output, PSUM_BW*COL: read result.
REQ-016 SHALL have port clear, input, 1: start zero-fill of all entries.
REQ-017 SHALL have port clear_done, output, 1: one-cycle pulse when zero-fill completes.

Function
REQ-018 SHALL contain a DEPTH x PSUM_BW*COL storage array with synchronous read and write.
REQ-019 SHALL process accepted writes in a 2-stage pipeline: stage A latches request and reads the entry; stage B adds or overwrites and writes back; the result is visible in storage at the end of the cycle after acceptance.
REQ-020 SHALL treat in_acc as 0 when mode=1; when mode=0, in_acc SHALL be honoured.
REQ-021 SHALL perform the add per lane, signed, PSUM_BW bits, with no carry between lanes; overflow behaviour is set by REQ-032.
REQ-022 SHALL forward stage-B results and the most recently written entry to stage A and to the read path on address match, so back-to-back accumulates to the same address produce the full sum and no stall.
REQ-023 SHALL complete a read with rd_req at cycle T by asserting out_valid at T+1 with data reflecting every write accepted before T.
REQ-024 SHALL give rd_req priority over in_valid in the same cycle, driving in_ready low for that cycle.
REQ-025 SHALL implement FSM IDLE -> CLEAR on clear in IDLE; CLEAR writes zero to addresses 0..DEPTH-1, one per cycle, and then returns to IDLE, pulsing clear_done on the cycle of the final write.
REQ-026 SHALL enter CLEAR only after the stage A/B pipeline has drained; in_ready SHALL be low and rd_req SHALL be ignored while clear is pending or CLEAR is active.
REQ-027 SHALL ignore clear while in CLEAR, and the address counter SHALL not wrap beyond DEPTH-1.
REQ-028 SHALL hold out_data at its last value when out_valid is low.

Reset
REQ-029 SHALL, on reset, set FSM=IDLE, flush both pipeline stages and the forwarding registers, and set out_valid=0, out_data=0, clear_done=0, in_ready=1 in the following cycle.
REQ-030 SHALL, on reset during CLEAR, abort the fill, leave partially cleared contents as-is, and not pulse clear_done.
REQ-031 SHALL not initialise storage contents on reset.

Configuration
REQ-032 SHALL, with macro PSUM_SAT_EN defined, saturate each lane add to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1]; without it, SHALL wrap modulo 2^PSUM_BW.

Verification
REQ-033 SHALL cover this scenario: mode=0, overwrite addr 5 with all lanes 3, then accumulate 4 on 3 back-to-back cycles, then read addr 5 -> out_valid 1 cycle after rd_req, all lanes 15.
REQ-034 SHALL cover this scenario: mode=1, write 7 then in_acc=1 write 2 to addr 9, then read -> all lanes 2.
REQ-035 SHALL cover this scenario: rd_req and in_valid high in the same cycle -> in_ready=0 that cycle, read returns value before the write, and the write is accepted next cycle.
REQ-036 SHALL cover this scenario: lane 0 holds 32767, accumulate 1 -> 32767 with PSUM_SAT_EN, -32768 without it; lanes 1..7 are unaffected.
REQ-037 SHALL cover this scenario: clear with 2 writes in flight -> both writes land, then DEPTH zero writes, clear_done exactly once, and a read of any address returns 0.
REQ-038 SHALL cover this scenario: reset asserted at clear address 100 -> no clear_done, in_ready=1 the cycle after reset, and addr 2047 retains its prior value.
